psum_requant_drain: RTL

- Downstream neighbour of the PE array.
- After an accumulation pass, it drains the N_PEs partial sums serially from the array's psum_out chain by driving the array's shift control.
- Each sum is requantised to an activation: optional ReLU, rounded arithmetic right shift, saturation.
- Results are packed PACK-per-word into a 2-entry output FIFO with valid/ready handshake to the activation buffer writer.

---
 rtl/psum_requant_drain_pkg.sv | 23 ++
 rtl/psum_requant_drain_requant_unit.sv | 53 +++++
 rtl/psum_requant_drain.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/psum_requant_drain_pkg.sv
// rtl/psum_requant_drain_pkg.sv - shared types and constants for the psum drain/requantise path
// Holds the drain FSM encoding and the saturation bounds shared by requant users.
package psum_requant_drain_pkg;

  localparam int PSUM_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_WAIT_EMPTY = 2'd3
  } drain_state_e;

  function automatic longint sat_max(input int dw, input logic is_signed);
    return is_signed ? ((64'sd1 <<< (dw - 1)) - 64'sd1) : ((64'sd1 <<< dw) - 64'sd1);
  endfunction

  function automatic longint sat_min(input int dw, input logic is_signed);
    return is_signed ? -(64'sd1 <<< (dw - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/psum_requant_drain_requant_unit.sv
// rtl/psum_requant_drain_requant_unit.sv - combinational ReLU, round-half-up shift and saturate
// One extra bit of headroom keeps the rounding add from overflowing at full-scale inputs.
module psum_requant_drain_requant_unit
  import psum_requant_drain_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SHIFT_W    = 5
) (
  input  logic [PSUM_WIDTH-1:0] psum_i,
  input  logic                  relu_en_i,
  input  logic                  out_sign_i,
  input  logic [SHIFT_W-1:0]    shift_amt_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  sat_o
);

  localparam int XW = PSUM_WIDTH + 1;
  localparam logic signed [XW-1:0] S_MAX = XW'(sat_max(DATA_WIDTH, 1'b1));
  localparam logic signed [XW-1:0] S_MIN = XW'(sat_min(DATA_WIDTH, 1'b1));
  localparam logic signed [XW-1:0] U_MAX = XW'(sat_max(DATA_WIDTH, 1'b0));
  localparam logic signed [XW-1:0] U_MIN = XW'(sat_min(DATA_WIDTH, 1'b0));

  logic signed [XW-1:0] x_in;
  logic signed [XW-1:0] x_relu;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] x_rnd;
  logic signed [XW-1:0] x_shr;
  logic signed [XW-1:0] hi;
  logic signed [XW-1:0] lo;

  always_comb begin
    x_in   = $signed({psum_i[PSUM_WIDTH-1], psum_i});
    x_relu = (relu_en_i && x_in[XW-1]) ? '0 : x_in;
    // A zero shift needs no rounding constant; the arithmetic shift then passes through.
    rnd    = (shift_amt_i == '0) ? '0 : (XW'(1) << (shift_amt_i - SHIFT_W'(1)));
    x_rnd  = x_relu + rnd;
    x_shr  = x_rnd >>> shift_amt_i;
    hi     = out_sign_i ? S_MAX : U_MAX;
    lo     = out_sign_i ? S_MIN : U_MIN;
    sat_o  = 1'b0;
    if (x_shr > hi) begin
      value_o = hi[DATA_WIDTH-1:0];
      sat_o   = 1'b1;
    end else if (x_shr < lo) begin
      value_o = lo[DATA_WIDTH-1:0];
      sat_o   = 1'b1;
    end else begin
      value_o = x_shr[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_requant_drain.sv
// rtl/psum_requant_drain.sv - drains PE-array partial sums, requantises and packs them into a 2-deep FIFO
// shift_req is combinational so the PE chain only advances on cycles the element can be stored.
module psum_requant_drain
  import psum_requant_drain_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_PEs      = 16,
  parameter int PACK       = 4,
  parameter int SHIFT_W    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic                       out_sign,
  input  logic [SHIFT_W-1:0]         shift_amt,
  input  logic [PSUM_WIDTH-1:0]      psum_in,
  output logic                       shift_req,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 sat_cnt
);

  localparam int WW = DATA_WIDTH * PACK;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int EW = $clog2(N_PEs + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(N_PEs - 1);
  localparam bit HAS_PARTIAL = (N_PEs % PACK) != 0;

  drain_state_e state_q, state_d;

  logic               relu_q;
  logic               sign_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [LW-1:0]      lane_q, lane_d;
  logic [EW-1:0]      elem_q, elem_d;
  logic [WW-1:0]      word_q, word_d, word_ins;
  logic [7:0]         sat_q, sat_d;

  logic [WW-1:0]      fifo_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [WW-1:0]      push_data;

  logic [DATA_WIDTH-1:0] rq_value;
  logic                  rq_sat;
  logic                  lane_last, elem_last, start_ok;

  psum_requant_drain_requant_unit #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_W    (SHIFT_W)
  ) u_requant (
    .psum_i      (psum_in),
    .relu_en_i   (relu_q),
    .out_sign_i  (sign_q),
    .shift_amt_i (shift_q),
    .value_o     (rq_value),
    .sat_o       (rq_sat)
  );

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign lane_last  = (lane_q == LAST_LANE);
  assign elem_last  = (elem_q == LAST_ELEM);
  assign start_ok   = (state_q == ST_IDLE) && start;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_q[rd_ptr_q];
  assign pop        = out_valid && out_ready;
  assign sat_cnt    = sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_DRAIN;
      ST_DRAIN:      if (shift_req && elem_last) state_d = HAS_PARTIAL ? ST_FLUSH : ST_WAIT_EMPTY;
      ST_FLUSH:      if (!fifo_full) state_d = ST_WAIT_EMPTY;
      ST_WAIT_EMPTY: if (fifo_empty) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_req = 1'b0;
    push      = 1'b0;
    push_data = word_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        busy      = 1'b1;
        shift_req = !(lane_last && fifo_full);
        push      = shift_req && lane_last;
        push_data = word_ins;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        push = !fifo_full;
      end
      ST_WAIT_EMPTY: begin
        busy = !fifo_empty;
        done = fifo_empty;
      end
      default: ;
    endcase
  end

  // Current word with this cycle's requantised element dropped into its lane.
  always_comb begin
    int lane_idx;
    lane_idx = int'(lane_q);
    word_ins = word_q;
    word_ins[lane_idx*DATA_WIDTH +: DATA_WIDTH] = rq_value;
  end

  always_comb begin
    lane_d = lane_q;
    elem_d = elem_q;
    word_d = word_q;
    sat_d  = sat_q;
    if (start_ok) begin
      lane_d = '0;
      elem_d = '0;
      word_d = '0;
      sat_d  = '0;
    end else if (shift_req) begin
      elem_d = elem_q + EW'(1);
      lane_d = lane_last ? '0 : lane_q + LW'(1);
      word_d = lane_last ? '0 : word_ins;
      if (rq_sat && (sat_q != 8'hFF)) sat_d = sat_q + 8'd1;
    end else if ((state_q == ST_FLUSH) && push) begin
      word_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      relu_q  <= 1'b0;
      sign_q  <= 1'b0;
      shift_q <= '0;
      lane_q  <= '0;
      elem_q  <= '0;
      word_q  <= '0;
      sat_q   <= '0;
    end else begin
      if (start_ok) begin
        relu_q  <= relu_en;
        sign_q  <= out_sign;
        shift_q <= shift_amt;
      end
      lane_q <= lane_d;
      elem_q <= elem_d;
      word_q <= word_d;
      sat_q  <= sat_d;
    end
  end

  // Pushes are only issued with space free, so the count never exceeds two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
